// File: rtl/ahb_pkg.sv
// Shared definitions for the two-manager AHB arbiter.
// Holds the HTRANS/HBURST encodings, the arbiter state enum, the manager
// index constants and the burst-length decode function.
package ahb_pkg;

   localparam logic [1:0] HtransIdle   = 2'b00;
   localparam logic [1:0] HtransBusy   = 2'b01;
   localparam logic [1:0] HtransNonseq = 2'b10;
   localparam logic [1:0] HtransSeq    = 2'b11;

   localparam logic [2:0] HburstSingle = 3'b000;
   localparam logic [2:0] HburstIncr4  = 3'b011;
   localparam logic [2:0] HburstIncr8  = 3'b101;
   localparam logic [2:0] HburstIncr16 = 3'b111;

   // Manager indices, also the encoding of the Owner bit
   localparam logic MgrIfu = 1'b0;
   localparam logic MgrLsu = 1'b1;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StContend = 2'd1,
      StResume  = 2'd2
   } arb_state_e;

   // Number of beats in a burst; unsupported encodings count as one beat
   function automatic logic [4:0] burst_len(input logic [2:0] hburst);
      logic [4:0] len;
      case (hburst)
         HburstIncr4:  len = 5'd4;
         HburstIncr8:  len = 5'd8;
         HburstIncr16: len = 5'd16;
         default:      len = 5'd1;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// Bus-side signal bundle of the AHB arbiter.
//   IFUReq/LSUReq      manager requests (HTRANS != IDLE at each controller input)
//   HREADY             subordinate ready
//   HTRANS/HBURST      attributes of the currently selected transaction
//   *Save/*Restore     controls to the controller-input stages
//   *Disable           blocks a controller-input stage from the bus
//   LSUSelect          output mux select, 1 = LSU drives the bus
// Modport slave is the arbiter's view; modport master is the environment's view.
interface ahb_arbiter_if;
   import ahb_pkg::*;

   logic       IFUReq;
   logic       LSUReq;
   logic       HREADY;
   logic [1:0] HTRANS;
   logic [2:0] HBURST;
   logic       IFUSave;
   logic       IFURestore;
   logic       IFUDisable;
   logic       LSUSave;
   logic       LSURestore;
   logic       LSUDisable;
   logic       LSUSelect;

   modport slave (
      input  IFUReq, LSUReq, HREADY, HTRANS, HBURST,
      output IFUSave, IFURestore, IFUDisable, LSUSave, LSURestore, LSUDisable, LSUSelect
   );

   modport master (
      output IFUReq, LSUReq, HREADY, HTRANS, HBURST,
      input  IFUSave, IFURestore, IFUDisable, LSUSave, LSURestore, LSUDisable, LSUSelect
   );

endinterface

// File: rtl/ahb_beatcounter.sv
// Beat counter for the transaction currently on the bus.
//   clk_i, rst_i     clock, asynchronous active-high reset
//   hready_i         subordinate ready
//   htrans_i         HTRANS of the selected transaction
//   hburst_i         HBURST of the selected transaction
//   beat_count_o     beats accepted so far in the current burst
//   final_beat_o     the last beat of the burst is accepted this cycle
module ahb_beatcounter
   import ahb_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       hready_i,
   input  logic [1:0] htrans_i,
   input  logic [2:0] hburst_i,
   output logic [3:0] beat_count_o,
   output logic       final_beat_o
);

   logic [3:0] beat_count_d, beat_count_q;
   logic [4:0] len;
   logic       beat_accepted;

   always_comb begin
      len           = burst_len(hburst_i);
      beat_accepted = hready_i && (htrans_i != HtransIdle);
      final_beat_o  = beat_accepted && ({1'b0, beat_count_q} == (len - 5'd1));
      beat_count_d  = beat_count_q;
      if (final_beat_o) begin
         beat_count_d = '0;
      end else if (beat_accepted) begin
         beat_count_d = beat_count_q + 4'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         beat_count_q <= '0;
      end else begin
         beat_count_q <= beat_count_d;
      end
   end

   assign beat_count_o = beat_count_q;

endmodule

// File: rtl/ahb_arbiter.sv
// Two-manager AHB arbiter (IFU = index 0, LSU = index 1).
//   HCLK      bus clock
//   HRESET    asynchronous active-high reset
//   bus       ahb_arbiter_if.slave: requests, HREADY, selected HTRANS/HBURST in;
//             Save/Restore/Disable controls and LSUSelect out
// On contention the loser's pending transaction is saved, the winner runs its
// burst (CONTEND), then ownership passes back and the loser's transaction is
// restored (RESUME). A burst in progress is never interrupted.
// Optional macro AHB_ARB_ROUNDROBIN_EN: contention is resolved by alternating
// against the last owner instead of fixed LSU priority.
module ahb_arbiter
   import ahb_pkg::*;
(
   input logic          HCLK,
   input logic          HRESET,
   ahb_arbiter_if.slave bus
);

   arb_state_e state_d, state_q;
   logic       owner_d, owner_q;
   logic [3:0] beat_count;
   logic       final_beat;
   logic       locked;
   logic       both_req;
   logic       winner;
   logic       lsu_sel;
   logic [1:0] save, restore, dis;

`ifdef AHB_ARB_ROUNDROBIN_EN
   logic last_owner_d, last_owner_q;
`endif

   ahb_beatcounter u_beat (
      .clk_i        (HCLK),
      .rst_i        (HRESET),
      .hready_i     (bus.HREADY),
      .htrans_i     (bus.HTRANS),
      .hburst_i     (bus.HBURST),
      .beat_count_o (beat_count),
      .final_beat_o (final_beat)
   );

   assign locked   = (beat_count != 4'd0);
   assign both_req = bus.IFUReq && bus.LSUReq;

`ifdef AHB_ARB_ROUNDROBIN_EN
   assign winner = both_req ? ~last_owner_q : bus.LSUReq;
`else
   assign winner = bus.LSUReq ? MgrLsu : MgrIfu;
`endif

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      lsu_sel = owner_q;
      save    = '0;
      restore = '0;
      dis     = '0;
      case (state_q)
         StIdle: begin
            if (!locked) begin
               lsu_sel = winner;
               if (bus.HREADY) begin
                  owner_d = winner;
               end
               if (both_req) begin
                  dis[~winner] = 1'b1;
                  if (bus.HREADY) begin
                     save[~winner] = 1'b1;
                     state_d       = StContend;
                  end
               end
            end else if (both_req) begin
               // Burst in flight: current owner keeps the bus
               dis[~owner_q] = 1'b1;
            end
         end
         StContend: begin
            dis[~owner_q] = 1'b1;
            if (final_beat) begin
               owner_d = ~owner_q;
               state_d = StResume;
            end
         end
         StResume: begin
            restore[owner_q] = 1'b1;
            dis[~owner_q]    = 1'b1;
            if (bus.HREADY) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

`ifdef AHB_ARB_ROUNDROBIN_EN
   assign last_owner_d = owner_d;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         last_owner_q <= MgrIfu;
      end else begin
         last_owner_q <= last_owner_d;
      end
   end
`endif

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q <= StIdle;
         owner_q <= MgrIfu;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

   assign bus.LSUSelect  = lsu_sel;
   assign bus.IFUSave    = save[MgrIfu];
   assign bus.LSUSave    = save[MgrLsu];
   assign bus.IFURestore = restore[MgrIfu];
   assign bus.LSURestore = restore[MgrLsu];
   assign bus.IFUDisable = dis[MgrIfu];
   assign bus.LSUDisable = dis[MgrLsu];

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed table-driven bench for ahb_arbiter plus a few multi-cycle sequences.
module tb_ahb_arbiter;
   import ahb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   ahb_arbiter_if bus ();

   ahb_arbiter dut (
      .HCLK   (clk),
      .HRESET (rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Output vector order: {LSUSelect, IFUSave, IFURestore, IFUDisable, LSUSave, LSURestore, LSUDisable}
   localparam logic [6:0] ONone   = 7'b000_0000;
   localparam logic [6:0] OGrantL = 7'b110_1000;
   localparam logic [6:0] OContL  = 7'b100_1000;
   localparam logic [6:0] OResI   = 7'b001_0001;
   localparam logic [6:0] OLockI  = 7'b000_0001;
   localparam logic [6:0] OLsu    = 7'b100_0000;

   typedef struct {
      logic       rst;
      logic       ifu;
      logic       lsu;
      logic       rdy;
      logic [1:0] trans;
      logic [2:0] burst;
      logic [6:0] out;
      logic [1:0] st;
      logic [3:0] cnt;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic r, input logic i, input logic l, input logic h,
                               input logic [1:0] t, input logic [2:0] b, input logic [6:0] o,
                               input logic [1:0] s, input logic [3:0] c);
      vec_t v;
      v.rst = r; v.ifu = i; v.lsu = l; v.rdy = h; v.trans = t; v.burst = b;
      v.out = o; v.st = s; v.cnt = c;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] outs();
      return {bus.LSUSelect, bus.IFUSave, bus.IFURestore, bus.IFUDisable,
              bus.LSUSave, bus.LSURestore, bus.LSUDisable};
   endfunction

   task automatic drive(input logic i, input logic l, input logic h, input logic [1:0] t,
                        input logic [2:0] b);
      bus.IFUReq = i; bus.LSUReq = l; bus.HREADY = h; bus.HTRANS = t; bus.HBURST = b;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lsu_cycles;
      logic seen_restore;
      logic [0:5] alt_exp;

      drive(1'b0, 1'b0, 1'b1, HtransIdle, HburstSingle);

      // reset, single IFU request
      vq.push_back(mk(1, 0, 0, 1, 2'b00, 3'b000, ONone,   0, 0));
      vq.push_back(mk(0, 0, 0, 1, 2'b00, 3'b000, ONone,   0, 0));
      vq.push_back(mk(0, 1, 0, 1, 2'b10, 3'b000, ONone,   0, 0));
      vq.push_back(mk(0, 1, 0, 1, 2'b10, 3'b000, ONone,   0, 0));
      // contention, LSU INCR4
      vq.push_back(mk(0, 1, 1, 1, 2'b10, 3'b011, OGrantL, 0, 0));
      vq.push_back(mk(0, 1, 1, 1, 2'b11, 3'b011, OContL,  1, 1));
      vq.push_back(mk(0, 1, 1, 1, 2'b11, 3'b011, OContL,  1, 2));
      vq.push_back(mk(0, 1, 1, 1, 2'b11, 3'b011, OContL,  1, 3));
      vq.push_back(mk(0, 1, 1, 1, 2'b10, 3'b000, OResI,   2, 0));
      vq.push_back(mk(0, 0, 0, 1, 2'b00, 3'b000, ONone,   0, 0));
      // contention with wait states
      vq.push_back(mk(0, 1, 1, 1, 2'b10, 3'b011, OGrantL, 0, 0));
      vq.push_back(mk(0, 1, 1, 0, 2'b11, 3'b011, OContL,  1, 1));
      vq.push_back(mk(0, 1, 1, 0, 2'b11, 3'b011, OContL,  1, 1));
      vq.push_back(mk(0, 1, 1, 0, 2'b11, 3'b011, OContL,  1, 1));
      vq.push_back(mk(0, 1, 1, 1, 2'b11, 3'b011, OContL,  1, 1));
      vq.push_back(mk(0, 1, 1, 1, 2'b11, 3'b011, OContL,  1, 2));
      vq.push_back(mk(0, 1, 1, 0, 2'b11, 3'b011, OContL,  1, 3));
      vq.push_back(mk(0, 1, 1, 1, 2'b11, 3'b011, OContL,  1, 3));
      vq.push_back(mk(0, 1, 1, 0, 2'b10, 3'b000, OResI,   2, 0));
      vq.push_back(mk(0, 1, 1, 1, 2'b10, 3'b000, OResI,   2, 0));
      vq.push_back(mk(0, 0, 0, 1, 2'b00, 3'b000, ONone,   0, 0));
      // IFU INCR8 in flight, LSU arrives at beat count 3
      vq.push_back(mk(0, 1, 0, 1, 2'b10, 3'b101, ONone,   0, 0));
      vq.push_back(mk(0, 1, 0, 1, 2'b11, 3'b101, ONone,   0, 1));
      vq.push_back(mk(0, 1, 0, 1, 2'b11, 3'b101, ONone,   0, 2));
      vq.push_back(mk(0, 1, 1, 1, 2'b11, 3'b101, OLockI,  0, 3));
      vq.push_back(mk(0, 1, 1, 1, 2'b11, 3'b101, OLockI,  0, 4));
      vq.push_back(mk(0, 1, 1, 1, 2'b11, 3'b101, OLockI,  0, 5));
      vq.push_back(mk(0, 1, 1, 1, 2'b11, 3'b101, OLockI,  0, 6));
      vq.push_back(mk(0, 1, 1, 1, 2'b11, 3'b101, OLockI,  0, 7));
      vq.push_back(mk(0, 0, 1, 1, 2'b10, 3'b000, OLsu,    0, 0));
      vq.push_back(mk(0, 0, 0, 1, 2'b00, 3'b000, ONone,   0, 0));
      // reset in CONTEND at beat count 2, then a clean contention
      vq.push_back(mk(0, 1, 1, 1, 2'b10, 3'b011, OGrantL, 0, 0));
      vq.push_back(mk(0, 1, 1, 1, 2'b11, 3'b011, OContL,  1, 1));
      vq.push_back(mk(0, 1, 1, 0, 2'b11, 3'b011, OContL,  1, 2));
      vq.push_back(mk(1, 0, 0, 1, 2'b00, 3'b000, ONone,   0, 0));
      vq.push_back(mk(0, 1, 1, 1, 2'b10, 3'b011, OGrantL, 0, 0));
      vq.push_back(mk(0, 1, 1, 1, 2'b11, 3'b011, OContL,  1, 1));
      vq.push_back(mk(0, 1, 1, 1, 2'b11, 3'b011, OContL,  1, 2));
      vq.push_back(mk(0, 1, 1, 1, 2'b11, 3'b011, OContL,  1, 3));
      vq.push_back(mk(0, 1, 1, 1, 2'b10, 3'b000, OResI,   2, 0));
      vq.push_back(mk(0, 0, 0, 1, 2'b00, 3'b000, ONone,   0, 0));

      foreach (vq[i]) begin
         @(negedge clk);
         rst = vq[i].rst;
         drive(vq[i].ifu, vq[i].lsu, vq[i].rdy, vq[i].trans, vq[i].burst);
         #1;
         chk($sformatf("vec%0d outputs", i), 32'(outs()), 32'(vq[i].out));
         chk($sformatf("vec%0d state", i), 32'(dut.state_q), 32'(vq[i].st));
         chk($sformatf("vec%0d beatcount", i), 32'(dut.beat_count), 32'(vq[i].cnt));
      end

      // Continuous dual SINGLE requests: bus owner alternates LSU, IFU
      alt_exp = 6'b110110;
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b1, HtransNonseq, HburstSingle);
      for (int k = 0; k < 6; k++) begin
         if (k != 0) @(negedge clk);
         #1;
         chk($sformatf("alt%0d LSUSelect", k), 32'(bus.LSUSelect), 32'(alt_exp[k]));
         chk($sformatf("alt%0d save_restore_excl", k),
             32'((bus.IFUSave && bus.IFURestore) || (bus.LSUSave && bus.LSURestore)), 32'd0);
      end

      // LSU INCR16 preempting IFU: LSU holds the bus for exactly 16 beats
      lsu_cycles   = 0;
      seen_restore = 1'b0;
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b1, HtransNonseq, HburstIncr16);
      for (int k = 0; k < 40; k++) begin
         if (k != 0) @(negedge clk);
         #1;
         if (bus.IFURestore) begin
            seen_restore = 1'b1;
            break;
         end
         if (bus.LSUSelect) lsu_cycles++;
      end
      chk("incr16 restore_reached", 32'(seen_restore), 32'd1);
      chk("incr16 lsu_beats", 32'(lsu_cycles), 32'd16);

      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, HtransIdle, HburstSingle);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
